// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: types shared by the OTTER pipeline-control slice.
//   opcode_t   - RV32I major opcodes, shared with the core.
//   sb_entry_t - one packed scoreboard entry (register addresses are
//                zero-extended to SB_AW bits so the type is not tied to REG_AW).
//   SB_NOP     - the bubble entry (all fields zero).
package otter_pipe_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  // Widest register address the scoreboard can carry; REG_AW must not exceed it.
  localparam int unsigned SB_AW = 8;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             we;
    logic             is_load;
    logic [SB_AW-1:0] rs1;
    logic [SB_AW-1:0] rs2;
    logic             uses1;
    logic             uses2;
  } sb_entry_t;

  localparam sb_entry_t SB_NOP = '0;

endpackage

// File: rtl/otter_fwd_pick.sv
// otter_fwd_pick: priority search for the youngest scoreboard stage
// (k = 1..NSTAGES-1) that will write register src. Returns 0 when nothing
// matches, the source is not used, or the producer writes x0.
// Ports:
//   sb      - scoreboard entries, index 0 = EX (entry 0 is not searched)
//   src     - source register address of the EX instruction
//   use_src - EX instruction actually reads src
//   sel     - forwarding select (0 = regfile, k = stage k result)
module otter_fwd_pick
  import otter_pipe_pkg::*;
#(
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned SEL_W   = $clog2(NSTAGES + 1)
) (
  input  sb_entry_t        sb [NSTAGES],
  input  logic [SB_AW-1:0] src,
  input  logic             use_src,
  output logic [SEL_W-1:0] sel
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    sel = '0;
    for (int unsigned k = NSTAGES - 1; k >= 1; k--) begin
      if (use_src && sb[k].valid && sb[k].we && (sb[k].rd != '0) && (sb[k].rd == src))
        sel = SEL_W'(k);
    end
  end

  logic unused_sb;
  always_comb begin
    unused_sb = 1'b0;
    for (int unsigned k = 0; k < NSTAGES; k++)
      unused_sb = unused_sb ^ (^sb[k]);
  end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// otter_pipe_ctrl: hazard and pipeline-control unit for the pipelined OTTER.
// Tracks NSTAGES instructions from EX onward, drives operand-forwarding
// selects, the load-use stall/bubble and the redirect flush.
// Ports:
//   CLK, RST              - clock, synchronous active-high reset
//   ID_*                  - decode-stage instruction description
//   REDIRECT              - EX resolved a taken control transfer
//   MEM_STALL             - freezes the whole pipeline
//   FWD_SEL1/2            - EX operand source (0 = regfile, k = stage k)
//   STALL_IF/ID, BUBBLE_EX, FLUSH_IF/ID - pipeline control
//   STAGE_VALID           - valid bit per tracked stage
// Optional: `define PIPE_CTRL_PERF_EN adds saturating counters
//   PERF_STALL_CYC, PERF_BUBBLES, PERF_FLUSHES.
module otter_pipe_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_USE = 1,
  parameter int unsigned SEL_W    = $clog2(NSTAGES + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ID_VALID,
  input  logic [REG_AW-1:0]  ID_RS1,
  input  logic [REG_AW-1:0]  ID_RS2,
  input  logic               ID_USES_RS1,
  input  logic               ID_USES_RS2,
  input  logic [REG_AW-1:0]  ID_RD,
  input  logic               ID_WE,
  input  logic               ID_IS_LOAD,
  input  logic               REDIRECT,
  input  logic               MEM_STALL,
  output logic [SEL_W-1:0]   FWD_SEL1,
  output logic [SEL_W-1:0]   FWD_SEL2,
  output logic               STALL_IF,
  output logic               STALL_ID,
  output logic               BUBBLE_EX,
  output logic               FLUSH_IF,
  output logic               FLUSH_ID,
  output logic [NSTAGES-1:0] STAGE_VALID
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        PERF_STALL_CYC,
  output logic [31:0]        PERF_BUBBLES,
  output logic [31:0]        PERF_FLUSHES
`endif
);

  sb_entry_t        sb [NSTAGES];
  sb_entry_t        id_entry;
  logic             redirect_act;
  logic             load_use;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [SEL_W-1:0] sel1;
  logic [SEL_W-1:0] sel2;

  always_comb begin
    id_entry = '{valid:   ID_VALID,
                 rd:      SB_AW'(ID_RD),
                 we:      ID_WE,
                 is_load: ID_IS_LOAD,
                 rs1:     SB_AW'(ID_RS1),
                 rs2:     SB_AW'(ID_RS2),
                 uses1:   ID_USES_RS1,
                 uses2:   ID_USES_RS2};
  end

  otter_fwd_pick #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_pick1 (
    .sb(sb), .src(sb[0].rs1), .use_src(sb[0].uses1), .sel(sel1)
  );

  otter_fwd_pick #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_pick2 (
    .sb(sb), .src(sb[0].rs2), .use_src(sb[0].uses2), .sel(sel2)
  );

  // A load is unforwardable while it sits in stages 0..LOAD_USE-1.
  always_comb begin
    load_use = 1'b0;
    for (int unsigned j = 0; j < LOAD_USE; j++) begin
      if (sb[j].valid && sb[j].is_load && sb[j].we && (sb[j].rd != '0) &&
          ((ID_USES_RS1 && (sb[j].rd == id_entry.rs1)) ||
           (ID_USES_RS2 && (sb[j].rd == id_entry.rs2))))
        load_use = 1'b1;
    end
    load_use = load_use & ID_VALID;
  end

  assign redirect_act = REDIRECT & sb[0].valid & ~MEM_STALL;

  // Priority: reset, memory freeze, redirect (kills the stalled instruction),
  // then load-use.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (RST) begin
      stall = 1'b0;
    end else if (MEM_STALL) begin
      stall = 1'b1;
    end else if (redirect_act) begin
      flush = 1'b1;
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign STALL_IF  = stall;
  assign STALL_ID  = stall;
  assign BUBBLE_EX = bubble;
  assign FLUSH_IF  = flush;
  assign FLUSH_ID  = flush;
  assign FWD_SEL1  = RST ? '0 : sel1;
  assign FWD_SEL2  = RST ? '0 : sel2;

  always_comb begin
    STAGE_VALID = '0;
    for (int unsigned k = 0; k < NSTAGES; k++)
      STAGE_VALID[k] = sb[k].valid & ~RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < NSTAGES; k++)
        sb[k] <= SB_NOP;
    end else if (!MEM_STALL) begin
      for (int unsigned k = NSTAGES - 1; k >= 1; k--)
        sb[k] <= sb[k-1];
      sb[0] <= (bubble || flush) ? SB_NOP : id_entry;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERF_STALL_CYC <= '0;
      PERF_BUBBLES   <= '0;
      PERF_FLUSHES   <= '0;
    end else begin
      if (stall && (PERF_STALL_CYC != '1))
        PERF_STALL_CYC <= PERF_STALL_CYC + 32'd1;
      if (bubble && (PERF_BUBBLES != '1))
        PERF_BUBBLES <= PERF_BUBBLES + 32'd1;
      if (flush && (PERF_FLUSHES != '1))
        PERF_FLUSHES <= PERF_FLUSHES + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
module tb_otter_pipe_ctrl;

  localparam int NS = 3;
  localparam int LU = 1;
  localparam int AW = 5;
  localparam int SW = $clog2(NS + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ID_VALID = 1'b0;
  logic [AW-1:0] ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
  logic          ID_USES_RS1 = 1'b0, ID_USES_RS2 = 1'b0;
  logic          ID_WE = 1'b0, ID_IS_LOAD = 1'b0;
  logic          REDIRECT = 1'b0, MEM_STALL = 1'b0;
  logic [SW-1:0] FWD_SEL1, FWD_SEL2;
  logic          STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_IF, FLUSH_ID;
  logic [NS-1:0] STAGE_VALID;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   PERF_STALL_CYC, PERF_BUBBLES, PERF_FLUSHES;
`endif

  always #5 CLK = ~CLK;

  otter_pipe_ctrl #(.NSTAGES(NS), .REG_AW(AW), .LOAD_USE(LU), .SEL_W(SW)) dut (
    .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .ID_RD(ID_RD), .ID_WE(ID_WE), .ID_IS_LOAD(ID_IS_LOAD),
    .REDIRECT(REDIRECT), .MEM_STALL(MEM_STALL),
    .FWD_SEL1(FWD_SEL1), .FWD_SEL2(FWD_SEL2),
    .STALL_IF(STALL_IF), .STALL_ID(STALL_ID), .BUBBLE_EX(BUBBLE_EX),
    .FLUSH_IF(FLUSH_IF), .FLUSH_ID(FLUSH_ID), .STAGE_VALID(STAGE_VALID)
`ifdef PIPE_CTRL_PERF_EN
    , .PERF_STALL_CYC(PERF_STALL_CYC), .PERF_BUBBLES(PERF_BUBBLES),
    .PERF_FLUSHES(PERF_FLUSHES)
`endif
  );

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit we; bit ld; bit u1; bit u2;
  } instr_t;

  typedef struct {
    bit rst; bit mst; bit redir; instr_t id;
  } stim_t;

  typedef struct {
    int f1; int f2; bit stall; bit bub; bit flush; int sv;
    bit perf_ok; longint p_st; longint p_bu; longint p_fl;
  } exp_t;

  // Model: pipe[0] is the instruction in EX, pipe[k] is k stages later.
  instr_t pipe[$];
  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  longint c_st = 0, c_bu = 0, c_fl = 0;
  bit     perf_known = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t empty_instr();
    instr_t z;
    z.v = 0; z.rd = 0; z.rs1 = 0; z.rs2 = 0; z.we = 0; z.ld = 0; z.u1 = 0; z.u2 = 0;
    return z;
  endfunction

  // Youngest older instruction that will write register r, or 0.
  function automatic int producer(int r, bit used);
    if (!used) return 0;
    for (int k = 1; k < NS; k++)
      if (pipe[k].v && pipe[k].we && pipe[k].rd != 0 && pipe[k].rd == r) return k;
    return 0;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit hz;
    e.f1 = 0; e.f2 = 0; e.stall = 0; e.bub = 0; e.flush = 0; e.sv = 0;
    e.perf_ok = perf_known; e.p_st = c_st; e.p_bu = c_bu; e.p_fl = c_fl;
    if (s.rst) return e;
    e.f1 = producer(pipe[0].rs1, pipe[0].u1);
    e.f2 = producer(pipe[0].rs2, pipe[0].u2);
    for (int k = 0; k < NS; k++)
      if (pipe[k].v) e.sv += (1 << k);
    hz = 0;
    if (s.id.v)
      for (int j = 0; j < LU; j++)
        if (pipe[j].v && pipe[j].ld && pipe[j].we && pipe[j].rd != 0 &&
            ((s.id.u1 && s.id.rs1 == pipe[j].rd) || (s.id.u2 && s.id.rs2 == pipe[j].rd)))
          hz = 1;
    if (s.mst) e.stall = 1;
    else if (s.redir && pipe[0].v) e.flush = 1;
    else if (hz) begin e.stall = 1; e.bub = 1; end
    return e;
  endfunction

  task automatic advance(input stim_t s, input exp_t e);
    instr_t n;
    if (s.rst) begin
      pipe = {};
      for (int k = 0; k < NS; k++) pipe.push_back(empty_instr());
      c_st = 0; c_bu = 0; c_fl = 0;
      perf_known = 1;
    end else begin
      c_st += e.stall; c_bu += e.bub; c_fl += e.flush;
      if (!s.mst) begin
        n = (e.bub || e.flush) ? empty_instr() : s.id;
        void'(pipe.pop_back());
        pipe.push_front(n);
      end
    end
  endtask

  // One clock: drive, record expectation, then step the model past the edge.
  task automatic step(input stim_t s);
    exp_t e;
    RST = s.rst; MEM_STALL = s.mst; REDIRECT = s.redir;
    ID_VALID = s.id.v; ID_RD = AW'(s.id.rd); ID_RS1 = AW'(s.id.rs1); ID_RS2 = AW'(s.id.rs2);
    ID_WE = s.id.we; ID_IS_LOAD = s.id.ld; ID_USES_RS1 = s.id.u1; ID_USES_RS2 = s.id.u2;
    #1;
    e = predict(s);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    advance(s, e);
  endtask

  function automatic stim_t ins(bit v, int rd, bit we, bit ld, int rs1, bit u1, int rs2, bit u2);
    stim_t s;
    s.rst = 0; s.mst = 0; s.redir = 0;
    s.id.v = v; s.id.rd = rd; s.id.we = we; s.id.ld = ld;
    s.id.rs1 = rs1; s.id.u1 = u1; s.id.rs2 = rs2; s.id.u2 = u2;
    return s;
  endfunction

  function automatic stim_t idle();
    return ins(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst   = ($urandom_range(0, 99) < 3);
    s.mst   = ($urandom_range(0, 99) < 12);
    s.redir = ($urandom_range(0, 99) < 12);
    if ($urandom_range(0, 99) < 80) begin
      s.id.v   = 1;
      s.id.rd  = $urandom_range(0, 3);
      s.id.rs1 = $urandom_range(0, 3);
      s.id.rs2 = $urandom_range(0, 3);
      s.id.u1  = $urandom_range(0, 1);
      s.id.u2  = $urandom_range(0, 1);
      s.id.ld  = ($urandom_range(0, 99) < 35);
      s.id.we  = ($urandom_range(0, 9) != 0);
    end
    return s;
  endfunction

  // Monitor: compares every cycle the stimulus has queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_sel1", FWD_SEL1, e.f1);
        chk("fwd_sel2", FWD_SEL2, e.f2);
        chk("stall_if", STALL_IF, e.stall);
        chk("stall_id", STALL_ID, e.stall);
        chk("bubble_ex", BUBBLE_EX, e.bub);
        chk("flush_if", FLUSH_IF, e.flush);
        chk("flush_id", FLUSH_ID, e.flush);
        chk("stage_valid", STAGE_VALID, e.sv);
`ifdef PIPE_CTRL_PERF_EN
        if (e.perf_ok) begin
          chk("perf_stall", PERF_STALL_CYC, e.p_st);
          chk("perf_bubbles", PERF_BUBBLES, e.p_bu);
          chk("perf_flushes", PERF_FLUSHES, e.p_fl);
        end
`endif
      end
    end
  end

  initial begin
    stim_t s;
    for (int k = 0; k < NS; k++) pipe.push_back(empty_instr());
    @(posedge CLK);
    #1;
    s = idle(); s.rst = 1;
    step(s); step(s);

    // ALU RAW on x5: forward from MEM, then from WB
    step(ins(1, 5, 1, 0, 0, 0, 0, 0));
    step(ins(1, 7, 1, 0, 5, 1, 0, 0));
    step(ins(1, 8, 1, 0, 5, 1, 5, 1));
    repeat (3) step(idle());

    // load-use on rs2, ID held through the stall
    step(ins(1, 6, 1, 1, 0, 0, 0, 0));
    s = ins(1, 9, 1, 0, 1, 1, 6, 1);
    step(s); step(s);
    repeat (3) step(idle());

    // x0 load destination: no stall, no forward
    step(ins(1, 0, 1, 1, 0, 0, 0, 0));
    step(ins(1, 9, 1, 0, 0, 1, 0, 1));
    repeat (3) step(idle());

    // redirect coinciding with a load-use hazard
    step(ins(1, 6, 1, 1, 0, 0, 0, 0));
    s = ins(1, 9, 1, 0, 6, 1, 0, 0); s.redir = 1;
    step(s);
    repeat (2) step(idle());

    // redirect with EX empty is ignored
    s = idle(); s.redir = 1;
    step(s);

    // memory stall for 4 cycles mid-stream
    step(ins(1, 5, 1, 0, 0, 0, 0, 0));
    step(ins(1, 6, 1, 0, 5, 1, 0, 0));
    s = ins(1, 7, 1, 0, 5, 1, 6, 1); s.mst = 1;
    repeat (4) step(s);
    s.mst = 0;
    step(s);
    repeat (3) step(idle());

    // reset in the middle of a load-use stall
    step(ins(1, 6, 1, 1, 0, 0, 0, 0));
    s = ins(1, 9, 1, 0, 6, 1, 0, 0);
    step(s);
    s.rst = 1;
    step(s);
    step(idle());

    repeat (1500) step(rnd());
    repeat (3) step(idle());

    @(posedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the pipelined OTTER core.
- Replaces the fixed two-stage RAW detection, single-cycle load-use stall and ad-hoc flush bits with a tracked per-stage scoreboard.
- Handles a configurable pipeline depth after decode and a configurable load-use distance.
- Sits beside the ID/EX boundary. Drives the forwarding-mux selects, the IF/ID stall and flush, and the EX bubble.

Parameters:
- NSTAGES, 3: tracked stages from EX onward (index 0 = EX, 1 = MEM, 2 = WB, ...); must be ≥ 2.
- REG_AW, 5: register address width.
- LOAD_USE, 1: number of stages after a load (starting at EX) in which its data is not yet forwardable; range 1..NSTAGES-1.
- SEL_W, $clog2(NSTAGES+1): width of the forward selects.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- ID_VALID  in  1  decode stage holds a real, unflushed instruction.
- ID_RS1, ID_RS2  in  REG_AW  decode source register addresses.
- ID_USES_RS1, ID_USES_RS2  in  1  decode instruction actually reads that source.
- ID_RD  in  REG_AW  decode destination register.
- ID_WE  in  1  decode instruction writes the register file.
- ID_IS_LOAD  in  1  decode instruction is a LOAD.
- REDIRECT  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- MEM_STALL  in  1  cache/memory stall; freezes the whole pipeline.
- FWD_SEL1, FWD_SEL2  out  SEL_W  source for the EX operands: 0 = regfile/ID data, k = result of stage k (1..NSTAGES-1).
- STALL_IF, STALL_ID  out  1  hold PC and the IF/ID register.
- BUBBLE_EX  out  1  load a NOP into the ID/EX register.
- FLUSH_IF, FLUSH_ID  out  1  invalidate the IF/ID and ID/EX contents.
- STAGE_VALID  out  NSTAGES  valid bit per tracked stage.

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous and active-high.
- Scoreboard: the unit keeps NSTAGES entries {valid, rd, we, is_load, rs1, rs2, uses1, uses2}; entry 0 is the instruction in EX.
- Reset: all entries invalid; every output 0. Reset has priority over all other inputs, including in the middle of a stall.
- Advance: each cycle with MEM_STALL=0, entry k+1 <= entry k. Entry 0 is loaded as follows:
  - bubble (all fields 0) if BUBBLE_EX or FLUSH_ID;
  - otherwise the ID inputs, with valid = ID_VALID.
- MEM_STALL=1: all entries hold. STALL_IF=STALL_ID=1, BUBBLE_EX=0, FLUSH_*=0. A REDIRECT seen under MEM_STALL is acted on in the first non-stalled cycle, because the EX entry is held.
- Forwarding (combinational, for entry 0):
  - FWD_SEL1 = smallest k in 1..NSTAGES-1 with entry k valid, we, rd≠0, rd==entry0.rs1 and uses1; otherwise 0. FWD_SEL2 is the same using rs2.
  - The youngest producer always wins.
  - Writes to x0 never forward.
- Load-use: hazard = ID_VALID and some entry j in 0..LOAD_USE-1 is valid, is_load, we, rd≠0, and its rd matches a used ID source.
  - On hazard: STALL_IF=STALL_ID=1 and BUBBLE_EX=1, combinationally in the same cycle.
  - The stall repeats each cycle until the load reaches stage LOAD_USE. With LOAD_USE=1 this gives exactly one bubble.
- Redirect: REDIRECT=1 with entry 0 valid and MEM_STALL=0 sets FLUSH_IF=FLUSH_ID=1 that cycle. The next EX entry is a bubble.
- Redirect vs load-use: REDIRECT has priority. In that cycle STALL_IF=STALL_ID=0 and BUBBLE_EX=0, because the stalled instruction is being flushed.
- REDIRECT with entry 0 invalid is ignored.
- Latency: all outputs are combinational from the inputs and current entries; entries update on the CLK edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs PERF_STALL_CYC[31:0], PERF_BUBBLES[31:0] and PERF_FLUSHES[31:0].
  - PERF_STALL_CYC increments on STALL_ID cycles.
  - PERF_BUBBLES increments on BUBBLE_EX cycles.
  - PERF_FLUSHES increments on FLUSH_ID cycles.
  - Counters saturate at 32'hFFFF_FFFF and clear on RST.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package otter_pipe_pkg holds:
  - the opcode_t enum, shared with the core;
  - typedef sb_entry_t, the packed scoreboard entry;
  - a NOP-entry constant.
- One sub-module, otter_fwd_pick: a combinational priority search returning the youngest matching stage index. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Back-to-back ALU RAW: add x5 in EX (entry 0), next instr reads x5 -> following cycle FWD_SEL1=1. One instr later -> FWD_SEL1=2. No stalls.
- Load-use with LOAD_USE=1: lw x6 followed by add reading x6 in rs2 -> STALL_IF=STALL_ID=BUBBLE_EX=1 for exactly 1 cycle, then FWD_SEL2=2.
- x0 destination: lw x0 then add reading x0 -> no stall; FWD_SEL=0.
- Redirect during load-use: taken branch in EX while ID has a load-use hazard -> FLUSH_IF=FLUSH_ID=1, STALL_*=0, BUBBLE_EX=0; next entry 0 invalid.
- MEM_STALL for 4 cycles mid-stream -> STAGE_VALID unchanged across all 4 cycles; forwarding selects stable; pipeline resumes with identical selects.
- RST asserted mid load-use stall -> next cycle STAGE_VALID=0 and all outputs 0. With PIPE_CTRL_PERF_EN defined, counters read 0.
